// File: rtl/instruction_ram.sv
// ---------------------------------------------------------------------------
// instruction_ram
//
// Purpose:
//   Stores the program bytes streamed in from the UART receiver. Bytes are
//   written through an internal write pointer, so the stream needs no
//   addressing. The stored program is played back either automatically,
//   one entry per clock (read mode), or one entry per DEBUG press (debug
//   mode).
//
// Ports:
//   clk       in   1           system clock, rising edge
//   rst       in   1           synchronous active-high reset
//   DEBUG     in   1           debounced, synchronized step button
//   MODE      in   2           0 = read, 1 = write, 2 = debug, 3 = reserved
//   address   in   DATA_WIDTH  reserved, ignored in every mode
//   data_in   in   DATA_WIDTH  byte from the UART receiver
//   data_out  out  DATA_WIDTH  selected instruction byte (combinational)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_ADDRESS = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DEBUG,
  input  logic [1:0]            MODE,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = MAX_ADDRESS + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_READ     = 2'd0;
  localparam logic [1:0] MODE_WRITE    = 2'd1;
  localparam logic [1:0] MODE_DEBUG    = 2'd2;

  localparam logic [DATA_WIDTH-1:0] IDLE_BYTE  = '0;
  localparam logic [DATA_WIDTH-1:0] DELIM_BYTE = DATA_WIDTH'('h24);
  localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      wr_cnt;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      dbg_ptr;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  prev_dbg;

  logic                  wr_en;
  logic                  have_data;
  logic [CNT_W-1:0]      last_idx;
  logic                  rd_can_step;
  logic                  dbg_can_step;
  logic                  dbg_rise;

  // The address port is kept only for pin compatibility with the old block.
  logic unused_address;
  assign unused_address = ^address;

  // A byte is captured only on the cycle it first appears, so a value held
  // for many cycles is stored once; the idle and delimiter bytes only serve
  // to separate repeated instructions and are never stored.
  assign wr_en = (MODE == MODE_WRITE)
              && (data_in != prev_data)
              && (data_in != IDLE_BYTE)
              && (data_in != DELIM_BYTE)
              && (wr_cnt != FULL_CNT);

  // Both playback pointers saturate on the last stored entry; with an
  // empty memory they are pinned at zero.
  assign have_data    = (wr_cnt != '0);
  assign last_idx     = wr_cnt - CNT_W'(1);
  assign rd_can_step  = have_data && (CNT_W'(rd_ptr)  < last_idx);
  assign dbg_can_step = have_data && (CNT_W'(dbg_ptr) < last_idx);
  assign dbg_rise     = DEBUG && !prev_dbg;

  // Control state: entry count, the two playback pointers and the one-cycle
  // history used for change/edge detection. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      dbg_ptr   <= '0;
      prev_data <= '0;
      prev_dbg  <= 1'b0;
    end else begin
      prev_data <= data_in;
      prev_dbg  <= DEBUG;
      if (wr_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if ((MODE == MODE_READ) && rd_can_step) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if ((MODE == MODE_DEBUG) && dbg_rise && dbg_can_step) begin
        dbg_ptr <= dbg_ptr + PTR_W'(1);
      end
    end
  end

  // Storage array. It is deliberately not reset; only the entry count is,
  // so stale contents beyond wr_cnt are never visible.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_cnt[PTR_W-1:0]] <= data_in;
    end
  end

  // Output select. Write mode and the reserved mode drive zero so the
  // decoder never sees half-written program bytes.
  always_comb begin
    data_out = '0;
    if (have_data) begin
      case (MODE)
        MODE_READ:  data_out = mem[rd_ptr];
        MODE_DEBUG: data_out = mem[dbg_ptr];
        default:    data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_ram.sv
// ---------------------------------------------------------------------------
// tb_instruction_ram
//
// Self-checking bench for instruction_ram. A reference model built from a
// queue of stored bytes and two saturating playback indices predicts
// data_out every cycle; directed steps add fixed expected values from the
// program-load scenarios, and a randomized phase exercises mode mixing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instruction_ram;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       DEBUG;
  logic [1:0] MODE;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] stored [$];
  int         rd_idx;
  int         dbg_idx;
  logic [7:0] last_data;
  logic       last_dbg;

  instruction_ram #(
    .DATA_WIDTH (8),
    .MAX_ADDRESS(255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .DEBUG   (DEBUG),
    .MODE    (MODE),
    .address (address),
    .data_in (data_in),
    .data_out(data_out)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  // Hard stop in case something in the sequence never returns.
  initial begin
    #2ms;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // What the decoder should see given the model's view of memory and MODE.
  function automatic logic [7:0] expected_out();
    if (stored.size() == 0) return 8'h00;
    case (MODE)
      2'd0:    return stored[rd_idx];
      2'd2:    return stored[dbg_idx];
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue(tag, {24'b0, data_out}, {24'b0, expected_out()});
  endtask

  task automatic checkCount(input string tag, input int expected);
    #2;
    checkValue(tag, 32'(dut.wr_cnt), 32'(expected));
    checkValue({tag, "_model"}, 32'(stored.size()), 32'(expected));
  endtask

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic updateModel();
    if (rst) begin
      stored.delete();
      rd_idx  = 0;
      dbg_idx = 0;
      last_data = 8'h00;
      last_dbg  = 1'b0;
    end else begin
      case (MODE)
        2'd1: if (data_in != last_data && data_in != 8'h00 &&
                  data_in != 8'h24 && stored.size() < DEPTH)
                stored.push_back(data_in);
        2'd0: if (rd_idx < stored.size() - 1) rd_idx++;
        2'd2: if (DEBUG && !last_dbg && dbg_idx < stored.size() - 1) dbg_idx++;
        default: ;
      endcase
      last_data = data_in;
      last_dbg  = DEBUG;
    end
  endtask

  // One cycle: drive on the falling edge, check the combinational output,
  // then let the rising edge commit and step the model. A non-negative
  // fixed_exp adds a directed check against a known constant.
  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic d,
                               input logic [7:0] x, input string tag,
                               input int fixed_exp = -1);
    @(negedge clk);
    rst     = r;
    MODE    = m;
    DEBUG   = d;
    data_in = x;
    address = 8'($urandom);
    #1;
    checkOutput(tag);
    if (fixed_exp >= 0) checkValue({tag, "_fixed"}, {24'b0, data_out}, 32'(fixed_exp));
    @(posedge clk);
    updateModel();
  endtask

  logic [7:0] stream [9] = '{8'h00, 8'h4A, 8'h24, 8'h4B, 8'h24,
                             8'h4C, 8'h24, 8'h4D, 8'h24};
  logic [7:0] playback [4] = '{8'h4A, 8'h4B, 8'h4C, 8'h4D};

  initial begin
    logic [7:0] b;
    rst = 1'b1; MODE = 2'd1; DEBUG = 1'b0; data_in = 8'h00; address = 8'h00;
    rd_idx = 0; dbg_idx = 0; last_data = 8'h00; last_dbg = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h00, "reset_a");
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h00, "reset_b");
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h00, "reset_out", 8'h00);
    checkCount("reset_wr_cnt", 0);

    $display("[TB] write stream");
    for (int i = 0; i < 9; i++)
      for (int c = 0; c < 4; c++)
        applyStimulus(1'b0, 2'd1, 1'b0, stream[i], "write_out", 8'h00);
    checkCount("write_wr_cnt", 4);

    $display("[TB] read playback");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h24, "read_seq", 32'(playback[i]));
    for (int i = 0; i < 25; i++)
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h24, "read_hold", 8'h4D);

    $display("[TB] debug stepping");
    applyStimulus(1'b0, 2'd2, 1'b0, 8'h24, "dbg_enter", 8'h4A);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 2'd2, 1'b1, 8'h24, "dbg_press");
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h24, "dbg_step", 32'(playback[i]));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd2, 1'b1, 8'h24, "dbg_sat_press", 8'h4D);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h24, "dbg_sat", 8'h4D);
    end
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 2'd2, 1'b1, 8'h24, "dbg_sat_held", 8'h4D);
    applyStimulus(1'b0, 2'd2, 1'b0, 8'h24, "dbg_sat_rel", 8'h4D);
    applyStimulus(1'b0, 2'd3, 1'b1, 8'h24, "mode3_out", 8'h00);

    $display("[TB] repeat and full");
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h00, "rep_reset");
    for (int c = 0; c < 2; c++) applyStimulus(1'b0, 2'd1, 1'b0, 8'h4A, "rep_w");
    for (int c = 0; c < 2; c++) applyStimulus(1'b0, 2'd1, 1'b0, 8'h24, "rep_w");
    for (int c = 0; c < 2; c++) applyStimulus(1'b0, 2'd1, 1'b0, 8'h4A, "rep_w");
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h24, "rep_w");
    checkCount("rep_wr_cnt", 2);
    for (int i = 2; i < DEPTH; i++) begin
      b = 8'($urandom_range(1, 255));
      if (b == 8'h24) b = 8'h25;
      applyStimulus(1'b0, 2'd1, 1'b0, b, "fill_w", 8'h00);
      applyStimulus(1'b0, 2'd1, 1'b0, 8'h24, "fill_d", 8'h00);
    end
    checkCount("full_wr_cnt", 256);
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h55, "over_w");
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h24, "over_d");
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h66, "over_w2");
    checkCount("over_wr_cnt", 256);

    applyStimulus(1'b0, 2'd2, 1'b0, 8'h66, "full_dbg0", 8'h4A);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 2'd2, 1'b1, 8'h66, "full_dbg_held");
    applyStimulus(1'b0, 2'd2, 1'b0, 8'h66, "full_dbg1", 8'h4A);
    for (int i = 0; i < 260; i++)
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h66, "full_read");

    $display("[TB] randomized");
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h00, "rand_reset");
    b = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1: b = 8'h24;
        2: ;
        default: b = 8'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0), b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_ram.md
# instruction_ram

The instruction RAM stores the program bytes that the MCU sends over the UART receive path. It uses an internal write pointer, so the byte stream needs no addressing. The stored program can then be played back in two ways: automatically, one byte per clock (read mode), or one byte per press of the DEBUG button (debug mode). It sits between the UART receiver and the instruction decode/display logic.

## Interface
Parameters:
- DATA_WIDTH, 8: width of the instruction byte, data_in and data_out.
- MAX_ADDRESS, 255: highest storage index. Depth is MAX_ADDRESS+1 entries.

Ports:
- clk  in  1: single system clock, rising-edge active (50 MHz nominal).
- rst  in  1: synchronous, active-high reset.
- DEBUG  in  1: debug-step button, already debounced and synchronized upstream.
- MODE  in  2: operating mode. 0 = read, 1 = write, 2 = debug, 3 = reserved.
- address  in  DATA_WIDTH: reserved. It is ignored in every mode.
- data_in  in  DATA_WIDTH: byte from the UART receiver. It holds its value for multiple cycles.
- data_out  out  DATA_WIDTH: the selected instruction byte.

## Operation
State:
- mem[0..MAX_ADDRESS]: the storage array.
- wr_cnt (0..MAX_ADDRESS+1): number of stored entries.
- rd_ptr: read-mode playback pointer.
- dbg_ptr: debug-mode playback pointer.
- prev_data: data_in registered each cycle.
- prev_dbg: DEBUG registered each cycle.

Reset:
- rst=1 at a clock edge clears wr_cnt, rd_ptr, dbg_ptr, prev_data and prev_dbg to 0.
- mem contents are not cleared.
- rst has priority over every other action.

Write (MODE=1):
- A write happens when data_in != prev_data, data_in != 0x00, data_in != 0x24 ('$') and wr_cnt <= MAX_ADDRESS.
- The write stores data_in at mem[wr_cnt] and increments wr_cnt.
- 0x00 is the idle value and 0x24 is the byte delimiter; neither is stored.
- Because a delimiter separates each byte, identical consecutive instructions are still stored separately.
- A byte held for many cycles is stored exactly once.
- When wr_cnt reaches MAX_ADDRESS+1 the memory is full; further bytes are dropped silently.
- data_out = 0 throughout write mode.

Read (MODE=0):
- data_out = mem[rd_ptr].
- rd_ptr increments on every clock edge while in read mode, until it reaches wr_cnt-1, then holds there.

Debug (MODE=2):
- data_out = mem[dbg_ptr].
- A DEBUG rising edge (DEBUG=1 and prev_dbg=0) increments dbg_ptr, saturating at wr_cnt-1.
- DEBUG held high for many cycles gives exactly one step.
- DEBUG is ignored in every other mode.
- Each pointer keeps its value across mode changes. Only rst returns a pointer to 0.

Other rules:
- MODE=3: data_out = 0, no state changes. prev_data and prev_dbg still update.
- Any mode with wr_cnt = 0: data_out = 0 and both pointers stay at 0.
- prev_data and prev_dbg update every cycle in every mode.

## Timing
- data_out is combinational from MODE, the pointers, wr_cnt and mem; there is no output register.
- After a mode switch, data_out is valid within the same cycle.
- A write commits at the first rising edge after data_in changes. The stored byte is readable from the following cycle.
- A DEBUG step is visible on data_out one cycle after the edge at which DEBUG is first sampled high.
- Read mode advances one entry per cycle. With N stored bytes, the last byte appears N-1 cycles after entering read mode.
- Upstream must hold each data_in value for at least 1 cycle. It must hold DEBUG low for at least 1 cycle between presses.

## Test plan
- Reset: assert rst with MODE=1 and data_in=0. Required: data_out = 0x00 and wr_cnt = 0.
- Write stream: MODE=1, send 00, 4A, 24, 4B, 24, 4C, 24, 4D, 24, each held 4 cycles. Required: wr_cnt = 4, mem[0..3] = 4A, 4B, 4C, 4D, data_out = 0 throughout.
- Read playback: after the write stream, set MODE=0. Required: data_out = 4A, 4B, 4C, 4D on successive cycles, then holds 4D for 25 cycles.
- Debug stepping: set MODE=2 with DEBUG=0. Required: data_out = 4A immediately. Each single 1-cycle DEBUG pulse (followed by 1 low cycle) yields 4B, 4C, then 4D.
- Debug saturation: four more DEBUG pulses. Required: data_out remains 4D; a press held for 10 cycles counts as one step.
- Repeat and full: write 4A, 24, 4A. Required: two 4A entries stored. After 256 stored bytes, a further byte is ignored and wr_cnt stays 256.
